// File: rtl/btc_host_link.sv
// btc_host_link
//
// Host-side driver for the tt_um_bitcoin miner's pin-level handshake.
// A block header is latched on an accepted start and sent to the miner as
// WORDS 16-bit words, MSB word first, one word per miner request. After the
// miner raises done, HASH_BYTES hash bytes are read back with an rq/ack
// handshake and placed into the hash output by miner address.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   start          one-cycle job start (accepted in IDLE, DONE, ERR)
//   header         block header, word i = header[639-16i -: 16]
//   busy           high while a job is in progress
//   hash_valid     high in DONE
//   hash           captured hash, miner address a -> hash[255-8a -: 8]
//   err            high in ERR (timeout or protocol error)
//   miner_uo       miner status: [5:0] addr, [6] done, [7] rq
//   miner_uio_out  miner read data
//   miner_ui       write phase: word[15:8]; read phase: {ack, 7'b0}
//   miner_uio      write phase: word[7:0]; otherwise 0
//
// Optional build macro
//   BTC_HOST_SYNC_EN  when defined, miner_uo and miner_uio_out pass through
//                     2-flop synchronizers before use (adds 2 cycles of
//                     input latency); use when the miner clock is unrelated.

module btc_host_link #(
  parameter int WORDS      = 40,
  parameter int HASH_BYTES = 32,
  parameter int TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [16*WORDS-1:0]       header,
  output logic                      busy,
  output logic                      hash_valid,
  output logic [8*HASH_BYTES-1:0]   hash,
  output logic                      err,
  input  logic [7:0]                miner_uo,
  input  logic [7:0]                miner_uio_out,
  output logic [7:0]                miner_ui,
  output logic [7:0]                miner_uio
);

  localparam int IW = $clog2(WORDS + 1);
  localparam int CW = $clog2(HASH_BYTES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, W_RQ, W_LOW, W_DONE, R_RQ, R_LOW, DONE, ERR
  } state_t;

  state_t state, state_nxt;

  logic [16*WORDS-1:0]     header_q, header_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           count, count_nxt;
  logic [TW-1:0]           wait_cnt, wait_cnt_nxt;
  logic [8*HASH_BYTES-1:0] hash_nxt;
  logic [7:0]              ui_nxt, uio_nxt;
  logic                    busy_nxt, hash_valid_nxt, err_nxt;

  logic [7:0]  uo_s, data_s;
  logic        rq, done_in, timeout_hit, in_wait;
  logic [5:0]  addr;
  logic [15:0] word_cur;

`ifdef BTC_HOST_SYNC_EN
  logic [7:0] uo_meta, uo_sync, data_meta, data_sync;

  // Two-stage synchronizers for the miner's status and read-data pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_meta   <= '0;
      uo_sync   <= '0;
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      uo_meta   <= miner_uo;
      uo_sync   <= uo_meta;
      data_meta <= miner_uio_out;
      data_sync <= data_meta;
    end
  end

  assign uo_s   = uo_sync;
  assign data_s = data_sync;
`else
  assign uo_s   = miner_uo;
  assign data_s = miner_uio_out;
`endif

  assign rq       = uo_s[7];
  assign done_in  = uo_s[6];
  assign addr     = uo_s[5:0];
  assign word_cur = header_q[16*WORDS-1 - 16*int'(idx) -: 16];

  assign in_wait = (state == W_RQ) || (state == W_LOW) || (state == W_DONE) ||
                   (state == R_RQ) || (state == R_LOW);

  // A timeout of 0 disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT != 0) && in_wait && (wait_cnt == TIMEOUT_V);

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      header_q   <= '0;
      idx        <= '0;
      count      <= '0;
      wait_cnt   <= '0;
      hash       <= '0;
      miner_ui   <= '0;
      miner_uio  <= '0;
      busy       <= 1'b0;
      hash_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      header_q   <= header_nxt;
      idx        <= idx_nxt;
      count      <= count_nxt;
      wait_cnt   <= wait_cnt_nxt;
      hash       <= hash_nxt;
      miner_ui   <= ui_nxt;
      miner_uio  <= uio_nxt;
      busy       <= busy_nxt;
      hash_valid <= hash_valid_nxt;
      err        <= err_nxt;
    end
  end

  // Next-state logic. The watchdog takes priority over a handshake event
  // arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = W_RQ;
      W_RQ: begin
        if (timeout_hit) state_nxt = ERR;
        else if (rq)     state_nxt = W_LOW;
      end
      W_LOW: begin
        if (timeout_hit) state_nxt = ERR;
        else if (!rq)    state_nxt = (idx == IW'(WORDS - 1)) ? W_DONE : W_RQ;
      end
      W_DONE: begin
        if (timeout_hit)  state_nxt = ERR;
        else if (done_in) state_nxt = R_RQ;
      end
      R_RQ: begin
        if (timeout_hit) state_nxt = ERR;
        else if (rq)     state_nxt = addr[5] ? ERR : R_LOW;
      end
      R_LOW: begin
        if (timeout_hit) state_nxt = ERR;
        else if (!rq)    state_nxt = (count == CW'(HASH_BYTES - 1)) ? DONE : R_RQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless a transition
  // below changes it, which keeps the last word on the pins through W_DONE.
  always_comb begin
    header_nxt = header_q;
    idx_nxt    = idx;
    count_nxt  = count;
    hash_nxt   = hash;
    ui_nxt     = miner_ui;
    uio_nxt    = miner_uio;

    if (state_nxt != state) wait_cnt_nxt = '0;
    else if (in_wait)       wait_cnt_nxt = wait_cnt + 1'b1;
    else                    wait_cnt_nxt = '0;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          header_nxt = header;
          hash_nxt   = '0;
          idx_nxt    = '0;
          count_nxt  = '0;
          ui_nxt     = '0;
          uio_nxt    = '0;
        end
      end
      W_RQ: begin
        if (state_nxt == W_LOW) begin
          ui_nxt  = word_cur[15:8];
          uio_nxt = word_cur[7:0];
        end
      end
      W_LOW: begin
        if (state_nxt == W_RQ) idx_nxt = idx + 1'b1;
      end
      W_DONE: begin
        if (state_nxt == R_RQ) begin
          ui_nxt  = '0;
          uio_nxt = '0;
        end
      end
      R_RQ: begin
        // Byte is captured on the same edge that raises ack.
        if (state_nxt == R_LOW) begin
          hash_nxt[8*HASH_BYTES-1 - 8*int'(addr[4:0]) -: 8] = data_s;
          ui_nxt = 8'h80;
        end
      end
      R_LOW: begin
        if ((state_nxt == R_RQ) || (state_nxt == DONE)) begin
          ui_nxt    = '0;
          count_nxt = count + 1'b1;
        end
      end
      default: ;
    endcase

    if ((state_nxt == ERR) && (state != ERR)) begin
      ui_nxt  = '0;
      uio_nxt = '0;
    end

    busy_nxt       = !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == ERR));
    hash_valid_nxt = (state_nxt == DONE);
    err_nxt        = (state_nxt == ERR);
  end

endmodule

// File: tb/tb_btc_host_link.sv
// tb_btc_host_link
//
// Bench for btc_host_link: a behavioural miner drives the pin handshake,
// a slot-array model of the miner's hash memory predicts the hash, and
// the header word sequence is derived by shifting the header arithmetically.
// Build macro BTC_HOST_SYNC_EN (shared with the design) moves every
// response two cycles later.

module tb_btc_host_link;

`ifdef BTC_HOST_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [639:0] header;
  logic         busy;
  logic         hash_valid;
  logic [255:0] hash;
  logic         err;
  logic [7:0]   miner_uo;
  logic [7:0]   miner_uio_out;
  logic [7:0]   miner_ui;
  logic [7:0]   miner_uio;

  int checks = 0;
  int errors = 0;

  logic [7:0]   slots [32];
  logic [639:0] genesis;
  logic [639:0] hdr;

  btc_host_link #(.WORDS(40), .HASH_BYTES(32), .TIMEOUT(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .header        (header),
    .busy          (busy),
    .hash_valid    (hash_valid),
    .hash          (hash),
    .err           (err),
    .miner_uo      (miner_uo),
    .miner_uio_out (miner_uio_out),
    .miner_ui      (miner_ui),
    .miner_uio     (miner_uio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [639:0] random_header();
    logic [639:0] h;
    h = '0;
    for (int i = 0; i < 20; i++) h = {h[607:0], 32'($urandom)};
    return h;
  endfunction

  function automatic logic [255:0] expected_hash();
    logic [255:0] h;
    h = '0;
    for (int a = 0; a < 32; a++) h = {h[247:0], slots[a]};
    return h;
  endfunction

  task automatic apply_stimulus(input logic [639:0] h);
    start  = 1'b1;
    header = h;
    @(negedge clk);
    start  = 1'b0;
    check_output("busy_after_start", busy, 1'b1);
    check_output("valid_after_start", hash_valid, 1'b0);
    check_output("err_after_start", err, 1'b0);
    check_output("hash_cleared", hash, 256'd0);
    for (int a = 0; a < 32; a++) slots[a] = 8'h00;
  endtask

  task automatic write_phase(input logic [639:0] h, input int dmax, input int stop_at);
    logic [15:0] exp_word;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, dmax)) @(negedge clk);
      miner_uo[7] = 1'b1;
      repeat (LAT) @(negedge clk);
      exp_word = 16'(h >> (16 * (39 - i)));
      check_output("word", {miner_ui, miner_uio}, exp_word);
      if (i == stop_at) return;
      miner_uo[7] = 1'b0;
      repeat (LAT) @(negedge clk);
    end
  endtask

  task automatic done_phase(input int dmax);
    repeat ($urandom_range(0, dmax)) @(negedge clk);
    miner_uo[6] = 1'b1;
    repeat (LAT) @(negedge clk);
    check_output("pins_after_done", {miner_ui, miner_uio}, 16'h0000);
  endtask

  // mode 0: ascending addr, data=addr; 1: descending addr, data=addr;
  // 2: random addr (repeats allowed), random data.
  task automatic read_phase(input int mode, input int dmax, input int glitch_at);
    logic [5:0] a;
    logic [7:0] d;
    for (int j = 0; j < 32; j++) begin
      case (mode)
        0:       begin a = 6'(j);      d = 8'(j);      end
        1:       begin a = 6'(31 - j); d = 8'(31 - j); end
        default: begin a = 6'($urandom_range(0, 31)); d = 8'($urandom); end
      endcase
      slots[a[4:0]] = d;
      repeat ($urandom_range(0, dmax)) @(negedge clk);
      miner_uo      = {1'b1, 1'b1, a};
      miner_uio_out = d;
      repeat (LAT - 1) @(negedge clk);
      check_output("ack_early", miner_ui, 8'h00);
      @(negedge clk);
      check_output("ack_rise", {miner_ui, miner_uio}, 16'h8000);
      miner_uo[7] = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      check_output("ack_hold", miner_ui, 8'h80);
      if (j == 31) check_output("valid_before_last", hash_valid, 1'b0);
      @(negedge clk);
      check_output("ack_fall", miner_ui, 8'h00);
      if (j == glitch_at) begin
        start  = 1'b1;
        header = random_header();
        @(negedge clk);
        start  = 1'b0;
        check_output("busy_after_ignored_start", busy, 1'b1);
      end
    end
  endtask

  task automatic run_job(input logic [639:0] h, input int dmax, input int mode,
                         input int glitch_at);
    apply_stimulus(h);
    write_phase(h, dmax, -1);
    done_phase(dmax);
    read_phase(mode, dmax, glitch_at);
    check_output("hash_valid_done", hash_valid, 1'b1);
    check_output("busy_done", busy, 1'b0);
    check_output("err_done", err, 1'b0);
    check_output("hash", hash, expected_hash());
    miner_uo      = 8'h00;
    miner_uio_out = 8'h00;
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    header        = '0;
    miner_uo      = 8'h00;
    miner_uio_out = 8'h00;
    genesis = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3BA3EDFD_7A7B12B2_7AC72C3E_67768F61_7FC81BC3_888A5132_3A9FB8AA_4B1E5E4A_29AB5F49_FFFF001D_1DAC2B7C;

    repeat (3) @(negedge clk);
    check_output("reset_pins", {miner_ui, miner_uio}, 16'h0000);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_err", err, 1'b0);
    check_output("reset_valid", hash_valid, 1'b0);
    check_output("reset_hash", hash, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] genesis header, ideal miner, ascending bytes");
    run_job(genesis, 0, 0, -1);

    $display("[TB] reverse address order");
    run_job(random_header(), 2, 1, -1);

    $display("[TB] random bytes with repeats, start ignored during read");
    run_job(random_header(), 3, 2, 10);

    $display("[TB] start in DONE with a new header");
    run_job(random_header(), 1, 2, -1);

    $display("[TB] reset during word 17");
    hdr = random_header();
    apply_stimulus(hdr);
    write_phase(hdr, 1, 17);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_pins", {miner_ui, miner_uio}, 16'h0000);
    check_output("midreset_busy", busy, 1'b0);
    check_output("midreset_err", err, 1'b0);
    check_output("midreset_valid", hash_valid, 1'b0);
    check_output("midreset_hash", hash, 256'd0);
    miner_uo      = 8'h00;
    miner_uio_out = 8'h00;
    rst_n         = 1'b1;
    @(negedge clk);
    run_job(random_header(), 1, 0, -1);

    $display("[TB] timeout with rq held low");
    apply_stimulus(random_header());
    repeat (100) @(negedge clk);
    check_output("pre_timeout_err", err, 1'b0);
    check_output("pre_timeout_busy", busy, 1'b1);
    @(negedge clk);
    check_output("timeout_err", err, 1'b1);
    check_output("timeout_busy", busy, 1'b0);
    check_output("timeout_pins", {miner_ui, miner_uio}, 16'h0000);
    check_output("timeout_valid", hash_valid, 1'b0);

    $display("[TB] restart from ERR, then bad read address");
    hdr = random_header();
    apply_stimulus(hdr);
    write_phase(hdr, 1, -1);
    done_phase(1);
    miner_uo = {1'b1, 1'b1, 6'h20};
    repeat (LAT) @(negedge clk);
    check_output("proto_err", err, 1'b1);
    check_output("proto_busy", busy, 1'b0);
    check_output("proto_pins", {miner_ui, miner_uio}, 16'h0000);
    check_output("proto_valid", hash_valid, 1'b0);
    miner_uo = 8'h00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
